// File: rtl/mmul_pkg.sv
// Shared types and defaults for the matrix-multiply engine scheduler.
package mmul_pkg;

    localparam int unsigned DW_DEF  = 32;
    localparam int unsigned LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPT,
        RESP
    } sched_state_t;

    typedef logic signed [DW_DEF-1:0] q16_16_t;

endpackage

// File: rtl/mmul_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [31:0] idx;

    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!any && req[idx[IDW-1:0]]) begin
                any    = 1'b1;
                gnt_id = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/mmul_sched.sv
// Round-robin scheduler sharing one fixed-latency matrix-multiply engine; one job in flight.
module mmul_sched
    import mmul_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned M    = 8,
    parameter int unsigned P    = 9,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned LAT  = LAT_DEF,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    output logic [IDW-1:0]    op_sel,
    output logic              op_en,
    input  logic [M*P*DW-1:0] eng_r,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [M*P*DW-1:0] rsp_data,
    output logic              busy
);

    localparam int unsigned RW = M * P * DW;
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    sched_state_t      state, state_d;
    logic [IDW-1:0]    ptr, ptr_d;
    logic [IDW-1:0]    op_sel_d;
    logic              op_en_d;
    logic [NREQ-1:0]   req_ready_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              rsp_valid_d;
    logic [IDW-1:0]    rsp_id_d;
    logic [RW-1:0]     rsp_data_d;
    logic              busy_d;
    logic [IDW-1:0]    gnt_id;
    logic              gnt_any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    // Next-state and next-output logic; req_ready/op_en pulse only in ISSUE.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        op_sel_d    = op_sel;
        op_en_d     = 1'b0;
        req_ready_d = '0;
        cnt_d       = cnt;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_data_d  = rsp_data;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    op_sel_d    = gnt_id;
                    op_en_d     = 1'b1;
                    req_ready_d = NREQ'(1) << gnt_id;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                ptr_d   = (op_sel == IDW'(NREQ - 1)) ? '0 : op_sel + IDW'(1);
                cnt_d   = CW'(LAT - 1);
                state_d = (LAT == 1) ? CAPT : WAIT;
            end
            WAIT: begin
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                rsp_data_d  = eng_r;
                rsp_id_d    = op_sel;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            op_sel    <= '0;
            op_en     <= 1'b0;
            req_ready <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            op_sel    <= op_sel_d;
            op_en     <= op_en_d;
            req_ready <= req_ready_d;
            cnt       <= cnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_data  <= rsp_data_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: doc/mmul_sched.md
# mmul_sched

Round-robin scheduler that shares one fixed-point matrix-multiply engine (Q16.16, 32-bit elements, fixed two-cycle latency) among NREQ requesters. It runs one job at a time:
- grants a requester;
- steers that requester's A/B operands into the engine for one cycle;
- waits out the engine pipeline;
- captures the M×P result and returns it with the requester id over a valid/ready response port.

It sits between the requester-side operand mux and the engine's R output.

## Interface
- NREQ, 4: number of requesters (≥2)
- M, 8: result rows
- P, 9: result columns
- DW, 32: element width (Q16.16)
- LAT, 2: engine latency in cycles from operand-sample edge to valid R (≥1)
- IDW, $clog2(NREQ): requester id width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester job request
- req_ready  out  NREQ  one-hot acceptance; operands consumed this cycle
- op_sel  out  IDW  operand-mux select into engine A/B
- op_en  out  1  operands on engine inputs are a real job this cycle
- eng_r  in  M*P*DW  engine result R, row-major
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  requester that owns rsp_data
- rsp_data  out  M*P*DW  captured result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPT, RESP.
- IDLE:
  - If any req_valid is set, pick the winner by round-robin from pointer ptr.
  - Register the winner into op_sel and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - op_en=1 and req_ready[op_sel]=1; that cycle's rising edge is the engine's operand-sample edge.
  - ptr ← (op_sel+1) mod NREQ.
  - Load wait counter with LAT−1.
  - Go to WAIT, or to CAPT directly when LAT=1.
- WAIT: decrement the counter; at 1, go to CAPT.
- CAPT (1 cycle): rsp_data ← eng_r, rsp_id ← op_sel; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - On rsp_valid&rsp_ready, go to IDLE.
- Requester protocol:
  - req_valid must stay high until req_ready.
  - Operands must be stable on the mux input in the ISSUE cycle.
  - If req_valid drops in ISSUE, the job still runs to completion.
- Round-robin search order: ptr, ptr+1, …, wrapping at NREQ−1 → 0. Every requester is guaranteed service within NREQ jobs.
- Only one job is in flight at a time; the engine's R is ignored outside CAPT.
- No arithmetic is done here; rsp_data is a bit-exact copy of eng_r.

## Timing
- Reset values: state=IDLE, ptr=0, op_sel=0, op_en=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Reset mid-job: the job is dropped and no response is issued. The requester must re-request.
- With req_valid seen in IDLE at cycle c:
  - ISSUE at c+1;
  - CAPT at c+1+LAT;
  - rsp_valid first high at c+2+LAT (c+4 for LAT=2).
- Back-to-back throughput: with rsp_ready tied high, one job per LAT+3 cycles. RESP lasts 1 cycle and is followed by 1 IDLE arbitration cycle.
- req_valid arriving while busy is held pending; it is arbitrated in the next IDLE cycle.
- Backpressure: rsp_ready low holds RESP indefinitely; no new grant is issued.
- Simultaneous requests in IDLE: exactly one req_ready bit is ever high.

## Structure
- Package mmul_pkg holds:
  - the state enum (sched_state_t);
  - the DW and LAT defaults;
  - a fixed-point element typedef (q16_16_t).
- Sub-module rr_arbiter:
  - parameter NREQ;
  - inputs req and ptr;
  - outputs gnt_id and any.
  - Combinational, instantiated once, used in IDLE.

## Test plan
- Single request, LAT=2: req_valid=4'b0100 at cycle 0 → req_ready=4'b0100 and op_sel=2 at cycle 1. At cycle 4, rsp_valid=1, rsp_id=2, rsp_data equals the eng_r value present at cycle 3.
- All four requesting continuously with rsp_ready=1 → grant order 0,1,2,3,0,…, with one job every 5 cycles.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_id and rsp_data stay constant, and no req_ready is asserted. On release, the next grant is 2 cycles later.
- Pointer wrap: after a grant to requester 3, a simultaneous 4'b1001 request → requester 0 is granted first, then 3.
- Reset mid-job: rst_n low during WAIT → all outputs 0 immediately. After release, the same requester re-requesting is granted in ISSUE 1 cycle after IDLE, with ptr=0 ordering.
- eng_r holds distinct patterns per cycle (e.g. cycle number replicated) → rsp_data matches only the CAPT-cycle pattern.
